// File: rtl/stream_s2p_gearbox_if.sv
// Stream bundle for the serial-to-parallel gearbox: serial input side, packed output side
// and FIFO fill reporting. The gearbox uses the slave modport, its environment the master.
interface stream_s2p_gearbox_if #(
  parameter int IN_W  = 1,
  parameter int RATIO = 2,
  parameter int DEPTH = 256
) ();
  localparam int OUT_W = IN_W * RATIO;
  localparam int LW    = $clog2(RATIO) + 1;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic [IN_W-1:0]  din_ser;
  logic             din_vld;
  logic             din_last;
  logic             dout_rdy;
  logic [OUT_W-1:0] dout_par;
  logic [LW-1:0]    dout_lanes;
  logic             dout_last;
  logic             dout_vld;
  logic             din_rdy;
  logic [OW-1:0]    occupancy;
  logic [OW-1:0]    availability;

  modport slave (
    input  din_ser, din_vld, din_last, din_rdy,
    output dout_rdy, dout_par, dout_lanes, dout_last, dout_vld, occupancy, availability
  );

  modport master (
    output din_ser, din_vld, din_last, din_rdy,
    input  dout_rdy, dout_par, dout_lanes, dout_last, dout_vld, occupancy, availability
  );
endinterface

// File: rtl/stream_s2p_gearbox.sv
// Packs RATIO serial samples into one word (with frame-end flush and zero padding) and
// queues the words in a first-word-fall-through FIFO whose head sits in a register.
module stream_s2p_gearbox #(
  parameter int IN_W      = 1,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 256,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  stream_s2p_gearbox_if.slave bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int LW    = $clog2(RATIO) + 1;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int EW    = OUT_W + LW + 1;

  localparam logic [OW-1:0] DEPTH_C   = OW'(DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  function automatic int lane_lsb(input int k);
    return MSB_FIRST ? (RATIO - 1 - k) * IN_W : k * IN_W;
  endfunction

  logic [LW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] pack_q, pack_d, merged_s;
  logic [EW-1:0]    entry_s;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    count_q, count_d, left_s, avail_q;
  logic [EW-1:0]    head_q, head_d;
  logic             vld_q, vld_d;
  logic             full_s, rdy_s, accept_s, push_s, pop_s;

  assign full_s   = (count_q == DEPTH_C);
  assign rdy_s    = rst_n && !full_s;
  assign accept_s = bus.din_vld && rdy_s;
  assign push_s   = accept_s && ((cnt_q == LAST_LANE) || bus.din_last);
  assign pop_s    = vld_q && bus.din_rdy;
  assign entry_s  = {bus.din_last, cnt_q + LW'(1), merged_s};

  // Pack stage: drop the sample into lane cnt, flush on the last lane or frame end.
  always_comb begin
    merged_s = pack_q;
    for (int k = 0; k < RATIO; k++) begin
      merged_s[lane_lsb(k) +: IN_W] = (cnt_q == LW'(k)) ? bus.din_ser
                                                        : pack_q[lane_lsb(k) +: IN_W];
    end
    if (push_s) begin
      cnt_d  = {LW{1'b0}};
      pack_d = {OUT_W{1'b0}};
    end else if (accept_s) begin
      cnt_d  = cnt_q + LW'(1);
      pack_d = merged_s;
    end else begin
      cnt_d  = cnt_q;
      pack_d = pack_q;
    end
  end

  // FIFO bookkeeping; the head register bypasses a push straight in when nothing else is queued.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    wr_ptr_d = wr_ptr_q + PW'(push_s);
    left_s   = count_q - OW'(pop_s);
    count_d  = left_s + OW'(push_s);
    if (left_s != {OW{1'b0}}) begin
      head_d = mem_q[rd_ptr_d];
      vld_d  = 1'b1;
    end else if (push_s) begin
      head_d = entry_s;
      vld_d  = 1'b1;
    end else begin
      head_d = {EW{1'b0}};
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {LW{1'b0}};
      pack_q   <= {OUT_W{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {OW{1'b0}};
      avail_q  <= DEPTH_C;
      head_q   <= {EW{1'b0}};
      vld_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      avail_q  <= DEPTH_C - count_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.dout_rdy     = rdy_s;
  assign bus.dout_par     = head_q[OUT_W-1:0];
  assign bus.dout_lanes   = head_q[OUT_W +: LW];
  assign bus.dout_last    = head_q[EW-1];
  assign bus.dout_vld     = vld_q;
  assign bus.occupancy    = count_q;
  assign bus.availability = avail_q;
endmodule

// File: tb/tb_stream_s2p_gearbox.sv
// Directed bench: three gearbox configurations (LSB-first and MSB-first 1x2, LSB-first 1x4),
// all with a 4-word FIFO.
module tb_stream_s2p_gearbox;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_s2p_gearbox_if #(.IN_W(1), .RATIO(2), .DEPTH(4)) ifa ();
  stream_s2p_gearbox_if #(.IN_W(1), .RATIO(2), .DEPTH(4)) ifb ();
  stream_s2p_gearbox_if #(.IN_W(1), .RATIO(4), .DEPTH(4)) ifc ();

  stream_s2p_gearbox #(.IN_W(1), .RATIO(2), .DEPTH(4), .MSB_FIRST(1'b0)) ua (.clk(clk), .rst_n(rst_n), .bus(ifa));
  stream_s2p_gearbox #(.IN_W(1), .RATIO(2), .DEPTH(4), .MSB_FIRST(1'b1)) ub (.clk(clk), .rst_n(rst_n), .bus(ifb));
  stream_s2p_gearbox #(.IN_W(1), .RATIO(4), .DEPTH(4), .MSB_FIRST(1'b0)) uc (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    tests++; if (ifa.dout_vld !== 1'b0) begin fails++; $display("FAIL rst_vld: got %b expected 0", ifa.dout_vld); end
    tests++; if (ifa.dout_par !== 2'b00) begin fails++; $display("FAIL rst_par: got %b expected 00", ifa.dout_par); end
    tests++; if (ifa.dout_lanes !== 2'd0) begin fails++; $display("FAIL rst_lanes: got %0d expected 0", ifa.dout_lanes); end
    tests++; if (ifa.dout_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b expected 0", ifa.dout_last); end
    tests++; if (ifa.occupancy !== 3'd0) begin fails++; $display("FAIL rst_occ: got %0d expected 0", ifa.occupancy); end
    tests++; if (ifa.availability !== 3'd4) begin fails++; $display("FAIL rst_avail: got %0d expected 4", ifa.availability); end
    tests++; if (ifa.dout_rdy !== 1'b0) begin fails++; $display("FAIL rst_rdy_low: got %b expected 0", ifa.dout_rdy); end
    tests++; if (ifc.availability !== 3'd4) begin fails++; $display("FAIL rst_avail_c: got %0d expected 4", ifc.availability); end
    rst_n = 1'b1;
    tick();
    tests++; if (ifa.dout_rdy !== 1'b1) begin fails++; $display("FAIL rst_rdy_release: got %b expected 1", ifa.dout_rdy); end
  endtask

  task automatic test_basic();
    ifa.din_rdy = 1'b1; ifa.din_vld = 1'b1; ifa.din_ser = 1'b1; tick();
    ifa.din_ser = 1'b0; tick();
    tests++; if (ifa.dout_vld !== 1'b1) begin fails++; $display("FAIL basic_w0_vld: got %b expected 1", ifa.dout_vld); end
    tests++; if (ifa.dout_par !== 2'b01) begin fails++; $display("FAIL basic_w0_par: got %b expected 01", ifa.dout_par); end
    tests++; if (ifa.dout_lanes !== 2'd2) begin fails++; $display("FAIL basic_w0_lanes: got %0d expected 2", ifa.dout_lanes); end
    tests++; if (ifa.dout_last !== 1'b0) begin fails++; $display("FAIL basic_w0_last: got %b expected 0", ifa.dout_last); end
    tests++; if (ifa.occupancy !== 3'd1) begin fails++; $display("FAIL basic_w0_occ: got %0d expected 1", ifa.occupancy); end
    ifa.din_ser = 1'b1; tick();
    tests++; if (ifa.dout_vld !== 1'b0) begin fails++; $display("FAIL basic_gap_vld: got %b expected 0", ifa.dout_vld); end
    tick();
    tests++; if (ifa.dout_par !== 2'b11 || ifa.dout_vld !== 1'b1) begin fails++; $display("FAIL basic_w1: got par %b vld %b expected 11/1", ifa.dout_par, ifa.dout_vld); end
    ifa.din_vld = 1'b0; tick();
    tests++; if (ifa.dout_vld !== 1'b0 || ifa.occupancy !== 3'd0) begin fails++; $display("FAIL basic_drain: got vld %b occ %0d expected 0/0", ifa.dout_vld, ifa.occupancy); end
  endtask

  task automatic test_lane_order();
    ifb.din_rdy = 1'b1; ifb.din_vld = 1'b1; ifb.din_ser = 1'b1; tick();
    ifb.din_ser = 1'b0; tick();
    tests++; if (ifb.dout_par !== 2'b10 || ifb.dout_vld !== 1'b1) begin fails++; $display("FAIL msb_w0: got par %b vld %b expected 10/1", ifb.dout_par, ifb.dout_vld); end
    ifb.din_ser = 1'b1; tick(); tick();
    tests++; if (ifb.dout_par !== 2'b11 || ifb.dout_vld !== 1'b1) begin fails++; $display("FAIL msb_w1: got par %b vld %b expected 11/1", ifb.dout_par, ifb.dout_vld); end
    ifb.din_vld = 1'b0; tick();
  endtask

  task automatic test_partial_flush();
    ifc.din_rdy = 1'b1; ifc.din_vld = 1'b1; ifc.din_ser = 1'b1; ifc.din_last = 1'b0; tick(); tick();
    ifc.din_last = 1'b1; tick();
    tests++; if (ifc.dout_par !== 4'b0111) begin fails++; $display("FAIL flush_par: got %b expected 0111", ifc.dout_par); end
    tests++; if (ifc.dout_lanes !== 3'd3) begin fails++; $display("FAIL flush_lanes: got %0d expected 3", ifc.dout_lanes); end
    tests++; if (ifc.dout_last !== 1'b1 || ifc.dout_vld !== 1'b1) begin fails++; $display("FAIL flush_last: got last %b vld %b expected 1/1", ifc.dout_last, ifc.dout_vld); end
    ifc.din_last = 1'b0; ifc.din_ser = 1'b1; tick();
    ifc.din_ser = 1'b0; tick(); tick();
    ifc.din_ser = 1'b1; tick();
    tests++; if (ifc.dout_par !== 4'b1001 || ifc.dout_lanes !== 3'd4 || ifc.dout_last !== 1'b0) begin fails++; $display("FAIL flush_next: got par %b lanes %0d last %b expected 1001/4/0", ifc.dout_par, ifc.dout_lanes, ifc.dout_last); end
    ifc.din_ser = 1'b0; tick();
    ifc.din_ser = 1'b1; tick();
    ifc.din_ser = 1'b0; tick();
    ifc.din_ser = 1'b1; ifc.din_last = 1'b1; tick();
    tests++; if (ifc.dout_par !== 4'b1010 || ifc.dout_lanes !== 3'd4 || ifc.dout_last !== 1'b1) begin fails++; $display("FAIL flush_full_last: got par %b lanes %0d last %b expected 1010/4/1", ifc.dout_par, ifc.dout_lanes, ifc.dout_last); end
    ifc.din_vld = 1'b0; ifc.din_last = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] bits;
    bits = 8'b0011_1001;
    ifa.din_rdy = 1'b0; ifa.din_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifa.din_ser = bits[i];
      tick();
    end
    tests++; if (ifa.occupancy !== 3'd4) begin fails++; $display("FAIL bp_occ_full: got %0d expected 4", ifa.occupancy); end
    tests++; if (ifa.availability !== 3'd0) begin fails++; $display("FAIL bp_avail_full: got %0d expected 0", ifa.availability); end
    tests++; if (ifa.dout_rdy !== 1'b0) begin fails++; $display("FAIL bp_rdy_full: got %b expected 0", ifa.dout_rdy); end
    ifa.din_ser = 1'b1; tick();
    tests++; if (ifa.dout_par !== 2'b01 || ifa.occupancy !== 3'd4) begin fails++; $display("FAIL bp_hold: got par %b occ %0d expected 01/4", ifa.dout_par, ifa.occupancy); end
    ifa.din_rdy = 1'b1; tick();
    tests++; if (ifa.dout_par !== 2'b10 || ifa.occupancy !== 3'd3 || ifa.dout_rdy !== 1'b1) begin fails++; $display("FAIL bp_pop1: got par %b occ %0d rdy %b expected 10/3/1", ifa.dout_par, ifa.occupancy, ifa.dout_rdy); end
    tick();
    ifa.din_vld = 1'b0;
    tests++; if (ifa.dout_par !== 2'b11 || ifa.occupancy !== 3'd2) begin fails++; $display("FAIL bp_pop2: got par %b occ %0d expected 11/2", ifa.dout_par, ifa.occupancy); end
    tick();
    tests++; if (ifa.dout_par !== 2'b00 || ifa.occupancy !== 3'd1 || ifa.dout_vld !== 1'b1) begin fails++; $display("FAIL bp_pop3: got par %b occ %0d vld %b expected 00/1/1", ifa.dout_par, ifa.occupancy, ifa.dout_vld); end
    tick();
    tests++; if (ifa.occupancy !== 3'd0 || ifa.availability !== 3'd4 || ifa.dout_vld !== 1'b0) begin fails++; $display("FAIL bp_empty: got occ %0d avail %0d vld %b expected 0/4/0", ifa.occupancy, ifa.availability, ifa.dout_vld); end
    ifa.din_vld = 1'b1; ifa.din_ser = 1'b0; tick();
    tests++; if (ifa.dout_par !== 2'b01 || ifa.dout_vld !== 1'b1) begin fails++; $display("FAIL bp_ninth: got par %b vld %b expected 01/1", ifa.dout_par, ifa.dout_vld); end
    ifa.din_vld = 1'b0; tick();
  endtask

  task automatic test_full_with_pop();
    ifa.din_rdy = 1'b0; ifa.din_vld = 1'b1; ifa.din_ser = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    ifa.din_ser = 1'b0; ifa.din_rdy = 1'b1; tick();
    tests++; if (ifa.occupancy !== 3'd3 || ifa.dout_rdy !== 1'b1) begin fails++; $display("FAIL fwp_pop: got occ %0d rdy %b expected 3/1", ifa.occupancy, ifa.dout_rdy); end
    tick();
    ifa.din_ser = 1'b1; tick();
    tests++; if (ifa.occupancy !== 3'd2 || ifa.dout_par !== 2'b11) begin fails++; $display("FAIL fwp_mix: got occ %0d par %b expected 2/11", ifa.occupancy, ifa.dout_par); end
    ifa.din_vld = 1'b0; tick();
    tests++; if (ifa.dout_par !== 2'b10 || ifa.occupancy !== 3'd1) begin fails++; $display("FAIL fwp_word: got par %b occ %0d expected 10/1", ifa.dout_par, ifa.occupancy); end
    tick();
    tests++; if (ifa.dout_vld !== 1'b0) begin fails++; $display("FAIL fwp_drain: got vld %b expected 0", ifa.dout_vld); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] bits;
    bits = 5'b10011;
    ifa.din_rdy = 1'b0; ifa.din_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifa.din_ser = bits[i];
      tick();
    end
    ifa.din_vld = 1'b0;
    tests++; if (ifa.occupancy !== 3'd2) begin fails++; $display("FAIL rm_pre_occ: got %0d expected 2", ifa.occupancy); end
    rst_n = 1'b0;
    #1;
    tests++; if (ifa.dout_vld !== 1'b0) begin fails++; $display("FAIL rm_vld: got %b expected 0", ifa.dout_vld); end
    tests++; if (ifa.occupancy !== 3'd0 || ifa.availability !== 3'd4) begin fails++; $display("FAIL rm_occ: got occ %0d avail %0d expected 0/4", ifa.occupancy, ifa.availability); end
    tests++; if (ifa.dout_rdy !== 1'b0) begin fails++; $display("FAIL rm_rdy: got %b expected 0", ifa.dout_rdy); end
    tick();
    rst_n = 1'b1;
    ifa.din_rdy = 1'b1; ifa.din_vld = 1'b1; ifa.din_ser = 1'b0; tick();
    ifa.din_ser = 1'b1; tick();
    tests++; if (ifa.dout_par !== 2'b10 || ifa.dout_lanes !== 2'd2 || ifa.dout_vld !== 1'b1) begin fails++; $display("FAIL rm_after: got par %b lanes %0d vld %b expected 10/2/1", ifa.dout_par, ifa.dout_lanes, ifa.dout_vld); end
    ifa.din_vld = 1'b0; tick();
  endtask

  initial begin
    ifa.din_ser = 1'b0; ifa.din_vld = 1'b0; ifa.din_last = 1'b0; ifa.din_rdy = 1'b0;
    ifb.din_ser = 1'b0; ifb.din_vld = 1'b0; ifb.din_last = 1'b0; ifb.din_rdy = 1'b0;
    ifc.din_ser = 1'b0; ifc.din_vld = 1'b0; ifc.din_last = 1'b0; ifc.din_rdy = 1'b0;
    test_reset();
    test_basic();
    test_lane_order();
    test_partial_flush();
    test_backpressure();
    test_full_with_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
